// File: rtl/mult_share_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: default sizing,
// tag width helper and the response tag layout at default sizing.
package mult_share_pkg;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NREQ_DEF    = 4;
  localparam int A_W_DEF     = 3;
  localparam int B_W_DEF     = 3;
  localparam int MUL_LAT_DEF = 2;
  localparam int ID_W_DEF    = id_w(NREQ_DEF);
  localparam int P_W_DEF     = A_W_DEF + B_W_DEF;

  // Response tag as it leaves the shared multiplier at default sizing.
  typedef struct packed {
    logic [ID_W_DEF-1:0] id;
    logic [P_W_DEF-1:0]  data;
  } rsp_def_t;

  localparam rsp_def_t RSP_IDLE = '0;

endpackage

// File: rtl/mult_share_arbiter_mult_pipe.sv
// Stall-able in-order multiplier pipe: operands captured in stage 0, product
// formed in the following stage (or at capture when only one stage exists).
module mult_pipe #(
  parameter  int A_W  = 3,
  parameter  int B_W  = 3,
  parameter  int ID_W = 2,
  parameter  int LAT  = 2,
  localparam int P_W  = A_W + B_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_advance,
  input  logic            i_valid,
  input  logic [A_W-1:0]  i_a,
  input  logic [B_W-1:0]  i_b,
  input  logic [ID_W-1:0] i_id,
  output logic            o_valid,
  output logic [P_W-1:0]  o_prod,
  output logic [ID_W-1:0] o_id,
  output logic [LAT-1:0]  o_stage_valid
);

  logic [LAT-1:0]  r_valid;
  logic [ID_W-1:0] r_id [LAT];

  // NOTE: state updates use non-blocking assignments so every stage samples
  // the pre-edge value of its predecessor; blocking here would collapse the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int k = 0; k < LAT; k++) r_id[k] <= '0;
    end else if (i_advance) begin
      r_valid[0] <= i_valid;
      r_id[0]    <= i_id;
      for (int k = 1; k < LAT; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_id[k]    <= r_id[k-1];
      end
    end
  end

  if (LAT == 1) begin : g_direct
    logic [P_W-1:0] r_prod;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_prod <= '0;
      end else if (i_advance) begin
        r_prod <= P_W'(i_a) * P_W'(i_b);
      end
    end

    assign o_prod = r_prod;
  end else begin : g_staged
    logic [A_W-1:0] r_a;
    logic [B_W-1:0] r_b;
    logic [P_W-1:0] r_prod [1:LAT-1];

    // NOTE: the product registers are pipeline flops, not a RAM, and the
    // response data must read zero out of reset, so every entry is reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_a <= '0;
        r_b <= '0;
        for (int k = 1; k < LAT; k++) r_prod[k] <= '0;
      end else if (i_advance) begin
        r_a       <= i_a;
        r_b       <= i_b;
        r_prod[1] <= P_W'(r_a) * P_W'(r_b);
        for (int k = 2; k < LAT; k++) r_prod[k] <= r_prod[k-1];
      end
    end

    assign o_prod = r_prod[LAT-1];
  end

  assign o_valid       = r_valid[LAT-1];
  assign o_id          = r_id[LAT-1];
  assign o_stage_valid = r_valid;

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin front end sharing one pipelined unsigned multiplier among NREQ
// requesters; products return in acceptance order tagged with the requester.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter  int NREQ    = NREQ_DEF,
  parameter  int A_W     = A_W_DEF,
  parameter  int B_W     = B_W_DEF,
  parameter  int MUL_LAT = MUL_LAT_DEF,
  localparam int ID_W    = id_w(NREQ),
  localparam int P_W     = A_W + B_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [NREQ*A_W-1:0] i_req_a,
  input  logic [NREQ*B_W-1:0] i_req_b,
  output logic [NREQ-1:0]   o_req_ready,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [P_W-1:0]    o_rsp_data,
  output logic [ID_W-1:0]   o_rsp_id,
  output logic              o_busy
);

  logic [ID_W-1:0]    r_ptr;
  logic               w_stall;
  logic               w_advance;
  logic               w_found;
  logic [ID_W-1:0]    w_win;
  logic [ID_W-1:0]    w_idx;
  logic               w_accept;
  logic [A_W-1:0]     w_a_arr [NREQ];
  logic [B_W-1:0]     w_b_arr [NREQ];
  logic [MUL_LAT-1:0] w_stage_valid;

  assign w_stall   = o_rsp_valid & ~i_rsp_ready;
  assign w_advance = ~w_stall;

  // NOTE: every always_comb output gets a default before the search loop so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int off = 0; off < NREQ; off++) begin
      w_idx = ID_W'((int'(r_ptr) + off) % NREQ);
      if (!w_found && i_req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_a_arr[i] = i_req_a[i*A_W +: A_W];
      w_b_arr[i] = i_req_b[i*B_W +: B_W];
    end
  end

  // Grants are held off while reset is asserted so nothing is accepted into
  // a pipe that is being cleared.
  assign o_req_ready = (w_found && i_enable && w_advance && rst_n)
                       ? (NREQ'(1) << w_win) : '0;
  assign w_accept    = |o_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
    end
  end

  mult_pipe #(
    .A_W  (A_W),
    .B_W  (B_W),
    .ID_W (ID_W),
    .LAT  (MUL_LAT)
  ) u_pipe (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_advance     (w_advance),
    .i_valid       (w_accept),
    .i_a           (w_a_arr[w_win]),
    .i_b           (w_b_arr[w_win]),
    .i_id          (w_win),
    .o_valid       (o_rsp_valid),
    .o_prod        (o_rsp_data),
    .o_id          (o_rsp_id),
    .o_stage_valid (w_stage_valid)
  );

  assign o_busy = |w_stage_valid;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed grant orders, products and latencies.
module tb_mult_share_arbiter;
  import mult_share_pkg::*;

  localparam int NREQ = NREQ_DEF;
  localparam int A_W  = A_W_DEF;
  localparam int B_W  = B_W_DEF;
  localparam int LAT  = MUL_LAT_DEF;
  localparam int ID_W = ID_W_DEF;
  localparam int P_W  = P_W_DEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic rsp_ready = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*A_W-1:0] req_a = '0;
  logic [NREQ*B_W-1:0] req_b = '0;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic [P_W-1:0]      rsp_data;
  logic [ID_W-1:0]     rsp_id;
  logic                busy;

  logic           s_enable = 1'b1;
  logic           s_valid = 1'b0;
  logic [A_W-1:0] s_a = '0;
  logic [B_W-1:0] s_b = '0;
  logic           s_ready;
  logic           s_rsp_valid;
  logic           s_rsp_ready = 1'b1;
  logic [P_W-1:0] s_rsp_data;
  logic [0:0]     s_rsp_id;
  logic           s_busy;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  typedef struct { int id; int cyc; } gnt_t;
  typedef struct { rsp_def_t r; int cyc; } rsp_t;
  typedef struct { int prod; int id; int age; } mop_t;

  gnt_t glog[$];
  rsp_t rlog[$];
  int   slog[$];
  mop_t mq[$];
  int   m_ptr = 0;
  logic [NREQ-1:0] acc_mask = '0;
  bit   auto_drop = 1'b0;

  mult_share_arbiter #(.NREQ(NREQ), .A_W(A_W), .B_W(B_W), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(enable),
    .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b),
    .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_id(rsp_id), .o_busy(busy)
  );

  mult_share_arbiter #(.NREQ(1), .A_W(A_W), .B_W(B_W), .MUL_LAT(1)) dut_single (
    .clk(clk), .rst_n(rst_n), .i_enable(s_enable),
    .i_req_valid(s_valid), .i_req_a(s_a), .i_req_b(s_b),
    .o_req_ready(s_ready), .o_rsp_valid(s_rsp_valid), .i_rsp_ready(s_rsp_ready),
    .o_rsp_data(s_rsp_data), .o_rsp_id(s_rsp_id), .o_busy(s_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: ordered list of ops in flight, each aging one step per
  // non-stalled edge; the oldest is presented once it has aged LAT steps.
  function automatic int m_winner();
    for (int k = 0; k < NREQ; k++) begin
      int idx = (m_ptr + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit m_rsp_valid();
    return (mq.size() > 0) && (mq[0].age == LAT);
  endfunction

  function automatic logic [NREQ-1:0] m_ready();
    logic [NREQ-1:0] r = '0;
    int w = m_winner();
    if (rst_n && enable && !(m_rsp_valid() && !rsp_ready) && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      mq.delete();
      m_ptr = 0;
    end else if (!(m_rsp_valid() && !rsp_ready)) begin
      w = m_winner();
      if (m_rsp_valid()) void'(mq.pop_front());
      foreach (mq[k]) mq[k].age++;
      if (enable && w >= 0) begin
        mq.push_back('{int'(req_a[w*A_W +: A_W]) * int'(req_b[w*B_W +: B_W]), w, 1});
        m_ptr = (w == NREQ - 1) ? 0 : w + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic e_valid;
    e_valid = m_rsp_valid();
    check("req_ready", req_ready, m_ready());
    check("rsp_valid", rsp_valid, e_valid);
    check("busy", busy, mq.size() > 0);
    if (e_valid) begin
      check("rsp_data", rsp_data, mq[0].prod);
      check("rsp_id", rsp_id, mq[0].id);
    end
    acc_mask = req_valid & req_ready;
    for (int i = 0; i < NREQ; i++) if (acc_mask[i]) glog.push_back('{i, cyc});
    if (rsp_valid && rsp_ready) rlog.push_back('{'{id: rsp_id, data: rsp_data}, cyc});
    if (s_rsp_valid) begin
      check("single_id", s_rsp_id, 0);
      slog.push_back(int'(s_rsp_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_drop) req_valid &= ~acc_mask;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_valid[i] = 1'b1;
    req_a[i*A_W +: A_W] = A_W'(a);
    req_b[i*B_W +: B_W] = B_W'(b);
  endtask

  task automatic wait_grants(input string name, input int count, input int max);
    int n = 0;
    while (glog.size() < count && n < max) begin tick(); n++; end
    check(name, glog.size(), count);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while ((busy || rsp_valid) && n < max) begin tick(); n++; end
    check(name, busy, 0);
  endtask

  task automatic clear_logs();
    glog.delete();
    rlog.delete();
  endtask

  initial begin
    int exp_g[5];
    int exp_d[5];
    int n;

    // Reset with every requester asking, then round-robin fairness.
    enable = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 7);
    #23;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    tick();
    rst_n = 1'b1;
    wait_grants("rr_grants", 5, 20);
    enable = 1'b0;
    req_valid = '0;
    wait_idle("rr_idle", 20);
    exp_g = '{0, 1, 2, 3, 0};
    exp_d = '{7, 14, 21, 28, 7};
    check("rr_rsp_count", rlog.size(), 5);
    for (int k = 0; k < 5 && k < glog.size(); k++) check("rr_grant_order", glog[k].id, exp_g[k]);
    for (int k = 0; k < 5 && k < rlog.size(); k++) begin
      check("rr_data", rlog[k].r.data, exp_d[k]);
      check("rr_id", rlog[k].r.id, exp_g[k]);
      check("rr_back_to_back", rlog[k].cyc - rlog[0].cyc, k);
    end
    if (rlog.size() > 0 && glog.size() > 0) check("rr_latency", rlog[0].cyc - glog[0].cyc, 2);

    // Single op from requester 2.
    clear_logs();
    auto_drop = 1'b1;
    enable = 1'b1;
    set_req(2, 5, 6);
    wait_grants("single_grant", 1, 10);
    wait_idle("single_idle", 10);
    check("single_count", rlog.size(), 1);
    if (rlog.size() > 0 && glog.size() > 0) begin
      check("single_data", rlog[0].r.data, 30);
      check("single_id", rlog[0].r.id, 2);
      check("single_latency", rlog[0].cyc - glog[0].cyc, 2);
    end

    // Back-pressure: pointer sits at 3, so grant order is 3,0,1,2.
    clear_logs();
    set_req(0, 3, 3);
    set_req(1, 4, 3);
    set_req(2, 5, 3);
    set_req(3, 6, 3);
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    check("bp_first_rsp", rsp_valid, 1);
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_ready_low", req_ready, 0);
      check("bp_data_hold", rsp_data, 18);
      check("bp_id_hold", rsp_id, 3);
    end
    rsp_ready = 1'b1;
    wait_grants("bp_grants", 4, 20);
    wait_idle("bp_idle", 20);
    exp_g = '{3, 0, 1, 2, 0};
    exp_d = '{18, 9, 12, 15, 0};
    check("bp_rsp_count", rlog.size(), 4);
    check("bp_grant_count", glog.size(), 4);
    for (int k = 0; k < 4 && k < rlog.size(); k++) begin
      check("bp_data", rlog[k].r.data, exp_d[k]);
      check("bp_id", rlog[k].r.id, exp_g[k]);
    end

    // Enable dropped after two accepts; requester 2 stays pending.
    clear_logs();
    set_req(0, 2, 2);
    set_req(1, 3, 1);
    set_req(2, 7, 7);
    wait_grants("en_grants", 2, 10);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("en_no_grant", req_ready, 0);
    end
    wait_idle("en_idle", 10);
    check("en_grant_count", glog.size(), 2);
    check("en_rsp_count", rlog.size(), 2);
    if (rlog.size() == 2) begin
      check("en_data0", rlog[0].r.data, 4);
      check("en_data1", rlog[1].r.data, 3);
    end
    req_valid = '0;

    // Reset while busy: op is lost, pointer returns to 0.
    clear_logs();
    enable = 1'b1;
    set_req(1, 7, 7);
    wait_grants("rb_grant", 1, 10);
    check("rb_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    check("rb_busy_cleared", busy, 0);
    check("rb_valid_cleared", rsp_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("rb_no_rsp", rlog.size(), 0);
    clear_logs();
    set_req(0, 7, 7);
    set_req(1, 0, 7);
    set_req(2, 7, 0);
    set_req(3, 5, 5);
    wait_grants("rb_grants", 4, 20);
    wait_idle("rb_idle", 20);
    exp_g = '{0, 1, 2, 3, 0};
    exp_d = '{49, 0, 0, 25, 0};
    check("rb_rsp_count", rlog.size(), 4);
    for (int k = 0; k < 4 && k < glog.size(); k++) check("rb_grant_order", glog[k].id, exp_g[k]);
    for (int k = 0; k < 4 && k < rlog.size(); k++) check("rb_data", rlog[k].r.data, exp_d[k]);

    // Single-requester build.
    slog.delete();
    s_valid = 1'b1;
    s_a = 3'd7;
    s_b = 3'd7;
    tick();
    s_a = 3'd3;
    s_b = 3'd2;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    check("single_build_count", slog.size(), 2);
    if (slog.size() == 2) begin
      check("single_build_d0", slog[0], 49);
      check("single_build_d1", slog[1], 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
